buart: RTL and testbench
========================

# buart

Byte-wide asynchronous serial transceiver (8N1, LSB first) with an integrated input-pin synchronizer on the receive line. It sits between the external RX/TX pins and the memory-mapped UART wrapper. The wrapper polls `valid`/`busy`, pulses `rd` to consume a received byte, and pulses `wr` to send one. Receiver and transmitter are fully independent and may run concurrently.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per bit (12 MHz / 115200 baud). Minimum legal value is 4.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: reset; synchronous, active-low.
- `rx`, input, 1: asynchronous serial input pin; idle level is high.
- `tx`, output, 1: serial output; idle level is high.
- `rd`, input, 1: one-cycle pulse that acknowledges and consumes the received byte.
- `wr`, input, 1: one-cycle pulse that starts transmission of `tx_data`.
- `tx_data`, input, 8: byte to send; sampled on the cycle `wr` is high.
- `valid`, output, 1: `rx_data` holds an unconsumed received byte.
- `busy`, output, 1: transmitter is sending a frame.
- `rx_data`, output, 8: last correctly framed received byte.

## Operation
- **Input synchronizer (pin stage):** `rx` passes through two flip-flops, giving `rxs`. These flops reset to 1. All receive logic uses `rxs` only.
- **Receiver FSM states:** IDLE, START, DATA, STOP.
  - IDLE: when `rxs` is 0, go to START and load the counter with `CLKS_PER_BIT/2` (integer division).
  - START: at the half-bit point, re-sample `rxs`. If it is 1, this is a glitch: return to IDLE. If it is 0, go to DATA and reload the counter with `CLKS_PER_BIT`.
  - DATA: sample one bit every `CLKS_PER_BIT` cycles at the bit centre, shifting bits in LSB first. After 8 bits, go to STOP.
  - STOP: sample at the stop-bit centre. If `rxs` is 1, copy the shift register to `rx_data` and set `valid` to 1. If `rxs` is 0 (framing error), discard the byte and leave `valid` and `rx_data` unchanged. In both cases return to IDLE immediately, so a new start edge can be detected from the second half of the stop bit onward.
- **`valid` rules:**
  - `rd` clears `valid` on the next edge.
  - If `rd` and a byte completion fall on the same cycle, completion wins: `valid` stays 1 and `rx_data` takes the new byte.
  - Overrun (a completion while `valid` is already 1): `rx_data` is overwritten and `valid` stays 1. No error flag.
  - `rd` while `valid` is 0 has no effect.
- **Transmitter FSM states:** IDLE, START, DATA, STOP.
  - When `wr` is 1 and `busy` is 0: latch `tx_data` and set `busy` to 1 on the next edge.
  - The frame is start bit (0), 8 data bits LSB first, then stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - `busy` falls after the last cycle of the stop bit.
  - `wr` while `busy` is 1 is ignored; the latched data is not disturbed.
  - Changes to `tx_data` outside the `wr` cycle have no effect.
- **Reset (`rst` low at a rising edge):** both FSMs go to IDLE, `tx` is 1, `busy` is 0, `valid` is 0, `rx_data` is 0x00, and the synchronizer flops are 1. Reset mid-frame aborts the frame, with `tx` high on the next cycle.

## Timing
- **TX start:** `wr` is sampled at edge N. At edge N+1, `busy` is 1 and `tx` is 0 (start bit begins).
  - Data bit k occupies cycles N+1+(k+1)·C through N+(k+2)·C, where C = `CLKS_PER_BIT`.
  - The stop bit ends at N+10·C, and `busy` is 0 from edge N+1+10·C.
  - Back-to-back: a `wr` in the first cycle that `busy` is 0 starts the next frame with no extra gap.
- **RX latency:** the `rx` falling edge reaches `rxs` 2 cycles later. `valid` rises about 2 + C/2 + 9·C cycles after the `rx` falling edge (±1 cycle), within the stop bit.
- **Tolerance:** the receiver accepts frames whose bit period deviates up to ±4% from C.
- **Outputs:** all outputs are registered; no combinational path from any input to any output.

## Test plan
Use `CLKS_PER_BIT` = 16 with a bench bit-period model.
- **Reset:** hold `rst`=0 for 3 cycles → `tx`=1, `busy`=0, `valid`=0, `rx_data`=0x00.
- **TX frame:** pulse `wr` with `tx_data`=0xA5 → `busy`=1 the next cycle. `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 16 cycles. `busy`=0 exactly 161 cycles after the `wr` edge. A second `wr` (0xFF) issued mid-frame is ignored.
- **RX byte:** drive the 0x3C frame on `rx` → `valid`=1 and `rx_data`=0x3C during the stop bit. Pulse `rd` → `valid`=0 on the next cycle.
- **RX glitch and framing error:** a 4-cycle low pulse on `rx` → no `valid`. A frame of 0x55 with stop bit 0 → `valid` stays 0 and `rx_data` is unchanged.
- **Overrun and collision:** send 0x11 then 0x22 with no `rd` → `rx_data`=0x22 and `valid`=1. Assert `rd` in the exact completion cycle of 0x33 → `valid` remains 1 and `rx_data`=0x33.
- **Loopback:** connect `tx` to `rx` and send 0x00, 0xFF, 0x81 back-to-back → each is received intact, in order.

Source files
------------

// File: rtl/buart.sv
// Byte-wide 8N1 serial transceiver, LSB first, with a two-flop synchronizer
// on the receive pin. Receiver and transmitter run independently.
module buart #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       valid,
  output logic       busy,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  logic          r_rx_meta, r_rxs;
  state_t        r_rx_state, w_rx_state;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt;
  logic [2:0]    r_rx_bit, w_rx_bit;
  logic [7:0]    r_rx_shift, w_rx_shift;
  logic [7:0]    r_rx_data, w_rx_data;
  logic          r_valid, w_valid;
  logic          w_rx_done;

  state_t        r_tx_state, w_tx_state;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt;
  logic [2:0]    r_tx_bit, w_tx_bit;
  logic [7:0]    r_tx_shift, w_tx_shift;
  logic          r_tx_go, w_tx_go;
  logic          r_tx, w_tx;
  logic          r_busy, w_busy;

  // Pin synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Receiver next state: counter counts down to 1, sampling at each bit centre.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_done  = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_rx_state = S_START;
          w_rx_cnt   = C_HALF;
        end else begin
          w_rx_cnt = r_rx_cnt;
        end
      end
      S_START: begin
        if (r_rx_cnt != C_ONE) begin
          w_rx_cnt = r_rx_cnt - C_ONE;
        end else if (r_rxs) begin
          w_rx_state = S_IDLE;
        end else begin
          w_rx_state = S_DATA;
          w_rx_cnt   = C_FULL;
          w_rx_bit   = 3'd0;
        end
      end
      S_DATA: begin
        if (r_rx_cnt != C_ONE) begin
          w_rx_cnt = r_rx_cnt - C_ONE;
        end else begin
          w_rx_shift = {r_rxs, r_rx_shift[7:1]};
          w_rx_cnt   = C_FULL;
          if (r_rx_bit == 3'd7) begin
            w_rx_state = S_STOP;
          end else begin
            w_rx_bit = r_rx_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        // Back to IDLE at mid-stop so the next start edge is caught early.
        if (r_rx_cnt != C_ONE) begin
          w_rx_cnt = r_rx_cnt - C_ONE;
        end else begin
          w_rx_state = S_IDLE;
          w_rx_done  = r_rxs;
        end
      end
      default: w_rx_state = S_IDLE;
    endcase
  end

  // Completion beats a same-cycle rd; overrun simply overwrites.
  always_comb begin
    w_valid   = r_valid;
    w_rx_data = r_rx_data;
    if (w_rx_done) begin
      w_valid   = 1'b1;
      w_rx_data = r_rx_shift;
    end else if (rd) begin
      w_valid = 1'b0;
    end else begin
      w_valid = r_valid;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_valid    <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_data  <= w_rx_data;
      r_valid    <= w_valid;
    end
  end

  // Transmitter next state; r_tx_go holds the latched request for one cycle.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx_go    = r_tx_go;
    w_tx       = r_tx;
    w_busy     = r_busy;
    case (r_tx_state)
      S_IDLE: begin
        if (r_tx_go) begin
          w_tx_state = S_START;
          w_tx_cnt   = C_FULL;
          w_tx_go    = 1'b0;
          w_tx       = 1'b0;
          w_busy     = 1'b1;
        end else if (wr) begin
          w_tx_shift = tx_data;
          w_tx_go    = 1'b1;
        end else begin
          w_tx = 1'b1;
        end
      end
      S_START: begin
        if (r_tx_cnt != C_ONE) begin
          w_tx_cnt = r_tx_cnt - C_ONE;
        end else begin
          w_tx_state = S_DATA;
          w_tx_cnt   = C_FULL;
          w_tx_bit   = 3'd0;
          w_tx       = r_tx_shift[0];
          w_tx_shift = {1'b0, r_tx_shift[7:1]};
        end
      end
      S_DATA: begin
        if (r_tx_cnt != C_ONE) begin
          w_tx_cnt = r_tx_cnt - C_ONE;
        end else begin
          w_tx_cnt = C_FULL;
          if (r_tx_bit == 3'd7) begin
            w_tx_state = S_STOP;
            w_tx       = 1'b1;
          end else begin
            w_tx_bit   = r_tx_bit + 3'd1;
            w_tx       = r_tx_shift[0];
            w_tx_shift = {1'b0, r_tx_shift[7:1]};
          end
        end
      end
      S_STOP: begin
        if (r_tx_cnt != C_ONE) begin
          w_tx_cnt = r_tx_cnt - C_ONE;
        end else begin
          w_tx_state = S_IDLE;
          w_busy     = 1'b0;
        end
      end
      default: begin
        w_tx_state = S_IDLE;
        w_tx       = 1'b1;
        w_busy     = 1'b0;
      end
    endcase
  end

  // Transmitter state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_go    <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx_go    <= w_tx_go;
      r_tx       <= w_tx;
      r_busy     <= w_busy;
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_buart.sv
// Directed bench for buart at 16 clocks per bit; inputs change and outputs
// are sampled on the falling edge.
module tb_buart;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_w, tx_w, valid, busy;
  logic [7:0] rx_data;
  int         n_checks = 0;
  int         n_errors = 0;

  assign rx_w = loop_en ? tx_w : rx_drv;

  buart #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx(rx_w), .tx(tx_w), .rd(rd), .wr(wr),
    .tx_data(tx_data), .valid(valid), .busy(busy), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Start bit plus 8 data bits (144 cycles); caller drives the stop bit.
  task automatic rx_frame_data(input logic [7:0] d);
    logic [7:0] v;
    v = d;
    rx_drv = 1'b0;
    repeat (16) tick();
    for (int b = 0; b < 8; b++) begin
      rx_drv = v[b];
      repeat (16) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (tx_w !== 1'b1) begin n_errors++; $display("FAIL reset_tx got %b want 1", tx_w); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_tx_frame();
    logic [9:0] exp_frame;
    exp_frame = {1'b1, 8'hA5, 1'b0};
    tx_data = 8'hA5;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    tx_data = 8'h00;
    for (int j = 0; j < 160; j++) begin
      tick();
      n_checks++;
      if (tx_w !== exp_frame[j / 16]) begin
        n_errors++; $display("FAIL tx_bit cycle %0d got %b want %b", j, tx_w, exp_frame[j / 16]);
      end
      if (j == 0 || j == 159) begin
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL tx_busy_high cycle %0d got %b want 1", j, busy); end
      end
      if (j == 40) begin wr = 1'b1; tx_data = 8'hFF; end
      if (j == 41) begin wr = 1'b0; tx_data = 8'h00; end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tx_busy_161 got %b want 0", busy); end
    n_checks++; if (tx_w !== 1'b1) begin n_errors++; $display("FAIL tx_idle got %b want 1", tx_w); end
  endtask

  task automatic test_rx_byte();
    logic       found;
    logic [7:0] got;
    found = 1'b0;
    got = 8'h00;
    rx_frame_data(8'h3C);
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL rx_early_valid got %b want 0", valid); end
    rx_drv = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (valid === 1'b1 && !found) begin found = 1'b1; got = rx_data; end
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rx_valid_in_stop got %b want 1", found); end
    n_checks++; if (got !== 8'h3C) begin n_errors++; $display("FAIL rx_data_3c got %h want 3c", got); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL rx_rd_clear got %b want 0", valid); end
  endtask

  task automatic test_glitch_framing();
    rx_drv = 1'b0;
    repeat (4) tick();
    rx_drv = 1'b1;
    repeat (200) tick();
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL glitch_valid got %b want 0", valid); end
    rx_frame_data(8'h55);
    rx_drv = 1'b0;
    repeat (16) tick();
    rx_drv = 1'b1;
    repeat (40) tick();
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL framing_valid got %b want 0", valid); end
    n_checks++; if (rx_data !== 8'h3C) begin n_errors++; $display("FAIL framing_rx_data got %h want 3c", rx_data); end
  endtask

  task automatic test_overrun_collision();
    rx_frame_data(8'h11);
    rx_drv = 1'b1;
    repeat (16) tick();
    n_checks++; if (valid !== 1'b1 || rx_data !== 8'h11) begin n_errors++; $display("FAIL overrun_first got %b/%h want 1/11", valid, rx_data); end
    rx_frame_data(8'h22);
    rx_drv = 1'b1;
    repeat (16) tick();
    n_checks++; if (valid !== 1'b1) begin n_errors++; $display("FAIL overrun_valid got %b want 1", valid); end
    n_checks++; if (rx_data !== 8'h22) begin n_errors++; $display("FAIL overrun_data got %h want 22", rx_data); end
    rx_frame_data(8'h33);
    rx_drv = 1'b1;
    repeat (10) tick();
    n_checks++; if (rx_data !== 8'h22) begin n_errors++; $display("FAIL collision_pre got %h want 22", rx_data); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++; if (valid !== 1'b1) begin n_errors++; $display("FAIL collision_valid got %b want 1", valid); end
    n_checks++; if (rx_data !== 8'h33) begin n_errors++; $display("FAIL collision_data got %h want 33", rx_data); end
    repeat (5) tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL collision_clear got %b want 0", valid); end
  endtask

  task automatic test_back_to_back_loopback();
    logic [7:0] sent [3];
    logic [7:0] recv [3];
    sent[0] = 8'h00; sent[1] = 8'hFF; sent[2] = 8'h81;
    for (int i = 0; i < 3; i++) recv[i] = 8'hXX;
    loop_en = 1'b1;
    tick();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int t;
          tx_data = sent[i];
          wr = 1'b1;
          tick();
          wr = 1'b0;
          tick();
          t = 0;
          while (busy === 1'b1 && t < 400) begin tick(); t++; end
          if (t >= 400) begin n_checks++; n_errors++; $display("FAIL loop_tx_timeout byte %0d busy %b want 0", i, busy); end
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int t;
          t = 0;
          while (valid !== 1'b1 && t < 400) begin tick(); t++; end
          if (t >= 400) begin
            n_checks++; n_errors++; $display("FAIL loop_rx_timeout byte %0d valid %b want 1", k, valid);
          end else begin
            recv[k] = rx_data;
            rd = 1'b1;
            tick();
            rd = 1'b0;
          end
        end
      end
    join
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (recv[i] !== sent[i]) begin n_errors++; $display("FAIL loop_byte %0d got %h want %h", i, recv[i], sent[i]); end
    end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_byte();
    test_glitch_framing();
    test_overrun_collision();
    test_back_to_back_loopback();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
